// File: rtl/fpu_op_sequencer_if.sv
// Operand/result stream bundle between the fpu operation sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the surrounding system.
`timescale 1ns/1ps
interface fpu_op_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      op_A_out;
    logic [31:0]      op_B_out;
    logic [31:0]      fpu_data_in;
    logic [3:0]       fpu_status_in;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [3:0]       res_status;
    logic [3:0]       sticky_status;
    logic             sticky_clear;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, fpu_data_in, fpu_status_in, res_ready, sticky_clear,
        output in_ready, op_A_out, op_B_out, res_valid, res_data, res_status,
               sticky_status, busy, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, fpu_data_in, fpu_status_in, res_ready, sticky_clear,
        input  in_ready, op_A_out, op_B_out, res_valid, res_data, res_status,
               sticky_status, busy, fifo_count
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Buffers operand pairs, holds each on the fpu for a settle window, then captures
// the fpu result/status and offers it on a valid/ready output with a sticky status OR.
`timescale 1ns/1ps
module fpu_op_sequencer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input logic               clock100KHz,
    input logic               reset,
    fpu_op_sequencer_if.slave bus
);
    localparam int               PTR_W       = $clog2(FIFO_DEPTH);
    localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL        = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [31:0]      mem_a_q [FIFO_DEPTH];
    logic [31:0]      mem_b_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [3:0]       res_status_q, res_status_d;
    logic [3:0]       sticky_q, sticky_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             push, pop, capture;

    // in_ready comes from the registered count only, so a same-cycle pop never opens a full FIFO
    assign push = bus.in_valid && (count_q != FULL);
    assign pop  = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_valid_d  = res_valid_q;
        capture      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    op_a_d   = mem_a_q[rd_ptr_q];
                    op_b_d   = mem_b_q[rd_ptr_q];
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == 8'd0) begin
                    capture      = 1'b1;
                    res_data_d   = bus.fpu_data_in;
                    res_status_d = bus.fpu_status_in;
                    res_valid_d  = 1'b1;
                    state_d      = HOLD;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a clear coincident with a capture keeps only the freshly captured flags
        sticky_d = (bus.sticky_clear ? 4'h0 : sticky_q) | (capture ? bus.fpu_status_in : 4'h0);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock100KHz) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.in_a;
            mem_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            settle_q     <= 8'd0;
            op_a_q       <= 32'h0;
            op_b_q       <= 32'h0;
            res_data_q   <= 32'h0;
            res_status_q <= 4'h0;
            sticky_q     <= 4'h0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            settle_q     <= settle_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            sticky_q     <= sticky_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready      = (count_q != FULL);
    assign bus.fifo_count    = count_q;
    assign bus.op_A_out      = op_a_q;
    assign bus.op_B_out      = op_b_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.res_status    = res_status_q;
    assign bus.sticky_status = sticky_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: fpu stub (data = A^B, status = A[3:0]) and a result scoreboard.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
    localparam int SETTLE = 8;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_op_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    fpu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
        .clock100KHz (clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    assign bus.fpu_data_in   = bus.op_A_out ^ bus.op_B_out;
    assign bus.fpu_status_in = bus.op_A_out[3:0];

    int          passed = 0;
    int          total  = 0;
    logic [35:0] exp_q [$];
    logic [35:0] exp_e;

    // result handshake takes place on this edge; values have been stable since the last falling edge
    always @(posedge clk) begin
        if (rst_n && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_extra: got status=%h data=%h, nothing expected",
                         bus.res_status, bus.res_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.res_status, bus.res_data} !== exp_e)
                    $display("FAIL scoreboard_result: got status=%h data=%h, expected status=%h data=%h",
                             bus.res_status, bus.res_data, exp_e[35:32], exp_e[31:0]);
                else passed++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 300 && !got; i++) begin
            if (bus.in_ready === 1'b1) got = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (got) exp_q.push_back({a[3:0], a ^ b});
        else begin
            total++;
            $display("FAIL push_timeout: pair a=%h not accepted, expected acceptance", a);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({bus.op_A_out, bus.op_B_out, bus.res_data} !== 96'h0)
            $display("FAIL reset_data: got opA=%h opB=%h res=%h, expected all 0",
                     bus.op_A_out, bus.op_B_out, bus.res_data);
        else passed++;
        total++;
        if ({bus.res_status, bus.sticky_status, bus.res_valid, bus.busy} !== 10'h0)
            $display("FAIL reset_ctrl: got st=%h sticky=%h vld=%b busy=%b, expected 0",
                     bus.res_status, bus.sticky_status, bus.res_valid, bus.busy);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd0)
            $display("FAIL reset_fifo: got in_ready=%b count=%0d, expected 1 and 0",
                     bus.in_ready, bus.fifo_count);
        else passed++;
    endtask

    task automatic test_single_op();
        bit early = 1'b0;
        apply_reset();
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h3F80_0000;
        bus.in_b      = 32'h4000_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_q.push_back({4'h0, 32'h7F80_0000});
        total++;
        if (bus.op_A_out !== 32'h0 || bus.fifo_count !== 3'd1)
            $display("FAIL single_after_push: got opA=%h count=%0d, expected 0 and 1",
                     bus.op_A_out, bus.fifo_count);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.op_A_out !== 32'h3F80_0000 || bus.op_B_out !== 32'h4000_0000 || bus.busy !== 1'b1)
            $display("FAIL single_ops_loaded: got opA=%h opB=%h busy=%b, expected 3f800000 40000000 1",
                     bus.op_A_out, bus.op_B_out, bus.busy);
        else passed++;
        for (int i = 1; i <= SETTLE; i++) begin
            @(negedge clk);
            if (i < SETTLE && bus.res_valid !== 1'b0) early = 1'b1;
        end
        total++;
        if (early || bus.res_valid !== 1'b1)
            $display("FAIL single_latency: early=%b res_valid=%b, expected early=0 valid=1",
                     early, bus.res_valid);
        else passed++;
        total++;
        if (bus.res_data !== 32'h7F80_0000 || bus.res_status !== 4'h0 || bus.sticky_status !== 4'h0)
            $display("FAIL single_result: got data=%h st=%h sticky=%h, expected 7f800000 0 0",
                     bus.res_data, bus.res_status, bus.sticky_status);
        else passed++;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_A_out !== 32'h3F80_0000)
            $display("FAIL single_done: got vld=%b busy=%b opA=%h, expected 0 0 3f800000",
                     bus.res_valid, bus.busy, bus.op_A_out);
        else passed++;
    endtask

    task automatic test_fifo_full();
        bit leaked = 1'b0;
        apply_reset();
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_pair(32'(i), 32'(i) << 8);
        total++;
        if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0)
            $display("FAIL full_count: got count=%0d in_ready=%b, expected 4 and 0",
                     bus.fifo_count, bus.in_ready);
        else passed++;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h6;
        bus.in_b     = 32'h600;
        repeat (3) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) leaked = 1'b1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (leaked) $display("FAIL full_stall: pair 6 accepted or count moved, expected stall at 4");
        else passed++;
        bus.res_ready = 1'b1;
        push_pair(32'h6, 32'h600);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0)
            $display("FAIL full_drain: %0d results outstanding, expected 0", exp_q.size());
        else passed++;
        total++;
        if (bus.sticky_status !== 4'h7)
            $display("FAIL full_sticky: got %h, expected 7", bus.sticky_status);
        else passed++;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit moved = 1'b0;
        bit seen  = 1'b0;
        apply_reset();
        bus.res_ready = 1'b0;
        push_pair(32'h0000_0011, 32'h0000_0022);
        push_pair(32'h0000_0033, 32'h0000_0044);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) $display("FAIL bp_valid_timeout: res_valid=%b, expected 1", bus.res_valid);
        else passed++;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0000_0033 || bus.res_status !== 4'h1)
                moved = 1'b1;
        end
        total++;
        if (moved) $display("FAIL bp_stable: got vld=%b data=%h st=%h, expected 1 00000033 1",
                            bus.res_valid, bus.res_data, bus.res_status);
        else passed++;
        total++;
        if (bus.op_A_out !== 32'h0000_0011 || bus.fifo_count !== 3'd1)
            $display("FAIL bp_no_pop: got opA=%h count=%0d, expected 00000011 and 1",
                     bus.op_A_out, bus.fifo_count);
        else passed++;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0)
            $display("FAIL bp_drain: %0d results outstanding, expected 0", exp_q.size());
        else passed++;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_sticky_clear();
        apply_reset();
        bus.res_ready = 1'b1;
        push_pair(32'h0000_0001, 32'h0000_0000);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (bus.sticky_status !== 4'h1 || exp_q.size() != 0)
            $display("FAIL sticky_first: got sticky=%h pending=%0d, expected 1 and 0",
                     bus.sticky_status, exp_q.size());
        else passed++;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h0000_0002;
        bus.in_b     = 32'h0000_0005;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_q.push_back({4'h2, 32'h0000_0007});
        @(negedge clk);
        repeat (SETTLE - 1) @(negedge clk);
        bus.sticky_clear = 1'b1;
        @(negedge clk);
        bus.sticky_clear = 1'b0;
        total++;
        if (bus.res_valid !== 1'b1 || bus.sticky_status !== 4'h2)
            $display("FAIL sticky_clear_capture: got vld=%b sticky=%h, expected 1 and 2",
                     bus.res_valid, bus.sticky_status);
        else passed++;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        bus.sticky_clear = 1'b1;
        @(negedge clk);
        bus.sticky_clear = 1'b0;
        total++;
        if (bus.sticky_status !== 4'h0)
            $display("FAIL sticky_clear_only: got %h, expected 0", bus.sticky_status);
        else passed++;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_settle();
        bit early = 1'b0;
        apply_reset();
        bus.res_ready = 1'b0;
        push_pair(32'h0000_0009, 32'h0000_0100);
        push_pair(32'h0000_000A, 32'h0000_0200);
        push_pair(32'h0000_000B, 32'h0000_0300);
        total++;
        if (bus.fifo_count !== 3'd2 || bus.busy !== 1'b1)
            $display("FAIL mid_setup: got count=%0d busy=%b, expected 2 and 1",
                     bus.fifo_count, bus.busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({bus.op_A_out, bus.op_B_out, bus.res_data, bus.res_status, bus.sticky_status,
             bus.res_valid, bus.busy, bus.fifo_count} !== 109'h0)
            $display("FAIL mid_reset_outputs: got opA=%h vld=%b busy=%b count=%0d, expected all 0",
                     bus.op_A_out, bus.res_valid, bus.busy, bus.fifo_count);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h0000_00A5;
        bus.in_b      = 32'h5A00_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_q.push_back({4'h5, 32'h5A00_00A5});
        @(negedge clk);
        total++;
        if (bus.op_A_out !== 32'h0000_00A5 || bus.fifo_count !== 3'd0)
            $display("FAIL mid_new_ops: got opA=%h count=%0d, expected 000000a5 and 0",
                     bus.op_A_out, bus.fifo_count);
        else passed++;
        for (int i = 1; i <= SETTLE; i++) begin
            @(negedge clk);
            if (i < SETTLE && bus.res_valid !== 1'b0) early = 1'b1;
        end
        total++;
        if (early || bus.res_valid !== 1'b1 || bus.res_data !== 32'h5A00_00A5)
            $display("FAIL mid_new_latency: early=%b vld=%b data=%h, expected 0 1 5a0000a5",
                     early, bus.res_valid, bus.res_data);
        else passed++;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3 * (SETTLE + 2)) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0)
            $display("FAIL mid_drain: pending=%0d busy=%b, expected 0 and 0",
                     exp_q.size(), bus.busy);
        else passed++;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_a         = 32'h0;
        bus.in_b         = 32'h0;
        bus.res_ready    = 1'b0;
        bus.sticky_clear = 1'b0;
        test_reset();
        test_single_op();
        test_fifo_full();
        test_backpressure();
        test_sticky_clear();
        test_reset_mid_settle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
